// File: rtl/xillybus_loop_fifo.sv
// ---------------------------------------------------------------------------
// xillybus_loop_fifo
//
// Loopback buffer in the bus_clk domain behind the Xillybus wrapper. Words
// written by the host on the hcw stream are held in a synchronous FIFO and
// returned on the hcr stream. Once the writer has closed its file and the
// FIFO has drained, end-of-file is raised to the reader. A sticky overflow
// flag and the current fill level are exported for GPIO/debug.
//
// Ports
//   bus_clk           in   single clock (wrapper user clock)
//   reset             in   synchronous, active-high; has priority over quiesce
//   quiesce           in   link down / core quiesced; synchronous flush
//   user_w_hcw_wren   in   write strobe
//   user_w_hcw_data   in   write data [DW-1:0]
//   user_w_hcw_full   out  FIFO full
//   user_w_hcw_open   in   host has the write file open
//   user_r_hcr_rden   in   read strobe
//   user_r_hcr_data   out  read data [DW-1:0], valid the cycle after rden
//   user_r_hcr_empty  out  FIFO empty
//   user_r_hcr_eof    out  end-of-file to the reader
//   user_r_hcr_open   in   host has the read file open
//   fill_level        out  words stored [AW:0], 0..2**AW
//   overflow          out  sticky: write strobe seen while full
// ---------------------------------------------------------------------------
module xillybus_loop_fifo #(
    parameter int DW = 32,
    parameter int AW = 9
) (
    input  logic          bus_clk,
    input  logic          reset,
    input  logic          quiesce,
    input  logic          user_w_hcw_wren,
    input  logic [DW-1:0] user_w_hcw_data,
    output logic          user_w_hcw_full,
    input  logic          user_w_hcw_open,
    input  logic          user_r_hcr_rden,
    output logic [DW-1:0] user_r_hcr_data,
    output logic          user_r_hcr_empty,
    output logic          user_r_hcr_eof,
    input  logic          user_r_hcr_open,
    output logic [AW:0]   fill_level,
    output logic          overflow
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DRAIN,
        ST_EOF
    } state_t;

    logic [DW-1:0] mem_q [DEPTH];

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          ovf_q, ovf_d;
    logic          eof_q, eof_d;
    logic [DW-1:0] rdata_q, rdata_d;
    state_t        state_q, state_d;
    logic          hcw_open_q;
    logic          hcr_open_q;

    logic          clr;
    logic          wr_acc;
    logic          rd_acc;
    logic          hcw_rise;
    logic          hcw_fall;
    logic          hcr_fall;

    // Datapath next-state. Acceptance is judged on the registered flags, so
    // a read on a full FIFO only frees its slot for the following cycle and a
    // read on an empty FIFO never bypasses a same-cycle write.
    always_comb begin
        clr     = reset | quiesce;
        wr_acc  = user_w_hcw_wren & ~full_q;
        rd_acc  = user_r_hcr_rden & ~empty_q;

        wptr_d  = wptr_q + AW'(wr_acc);
        rptr_d  = rptr_q + AW'(rd_acc);
        count_d = count_q + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);

        // Flags come from the next-state count so they never lag the count.
        full_d  = (count_d == (AW+1)'(DEPTH));
        empty_d = (count_d == '0);
        ovf_d   = ovf_q | (user_w_hcw_wren & full_q);
        rdata_d = rd_acc ? mem_q[rptr_q] : rdata_q;
    end

    assign hcw_rise = user_w_hcw_open & ~hcw_open_q;
    assign hcw_fall = ~user_w_hcw_open & hcw_open_q;
    assign hcr_fall = ~user_r_hcr_open & hcr_open_q;

    // EOF state machine, next-state logic.
    always_comb begin
        state_d = state_q;
        if (hcr_fall && !user_w_hcw_open) begin
            // Reader gone with no writer: back to idle, FIFO contents kept.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hcw_rise) state_d = ST_STREAM;
                end
                ST_STREAM: begin
                    if (hcw_fall) state_d = ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (hcw_rise)
                        state_d = ST_STREAM;
                    else if (count_d == '0 && user_r_hcr_open)
                        state_d = ST_EOF;
                end
                ST_EOF: begin
                    // A late write is kept; treat it as the stream resuming
                    // so eof drops together with empty.
                    if (wr_acc)
                        state_d = ST_STREAM;
                    else if (hcr_fall || hcw_rise)
                        state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
        eof_d = (state_d == ST_EOF);
    end

    always_ff @(posedge bus_clk) begin
        if (clr) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            eof_q   <= 1'b0;
            rdata_q <= '0;
            state_q <= ST_IDLE;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            ovf_q   <= ovf_d;
            eof_q   <= eof_d;
            rdata_q <= rdata_d;
            state_q <= state_d;
        end
        // The open samples keep tracking through a flush so that a file
        // still open afterwards is not mistaken for a fresh open edge.
        hcw_open_q <= user_w_hcw_open;
        hcr_open_q <= user_r_hcr_open;
    end

    // Storage array, no reset so it maps onto block RAM.
    always_ff @(posedge bus_clk) begin
        if (wr_acc) mem_q[wptr_q] <= user_w_hcw_data;
    end

    assign user_w_hcw_full  = full_q;
    assign user_r_hcr_empty = empty_q;
    assign user_r_hcr_data  = rdata_q;
    assign user_r_hcr_eof   = eof_q;
    assign fill_level       = count_q;
    assign overflow         = ovf_q;

endmodule

// File: tb/tb_xillybus_loop_fifo.sv
module tb_xillybus_loop_fifo;

    localparam int DW = 32;
    localparam int AW = 9;
    localparam int DEPTH = 512;

    logic          bus_clk = 1'b0;
    logic          reset = 1'b1;
    logic          quiesce = 1'b0;
    logic          user_w_hcw_wren = 1'b0;
    logic [DW-1:0] user_w_hcw_data = '0;
    logic          user_w_hcw_full;
    logic          user_w_hcw_open = 1'b0;
    logic          user_r_hcr_rden = 1'b0;
    logic [DW-1:0] user_r_hcr_data;
    logic          user_r_hcr_empty;
    logic          user_r_hcr_eof;
    logic          user_r_hcr_open = 1'b0;
    logic [AW:0]   fill_level;
    logic          overflow;

    int tests = 0;
    int fails = 0;

    logic [31:0] mq[$];     // reference FIFO contents
    logic [31:0] exp_q[$];  // scoreboard: read words due on the output
    logic        movf = 1'b0;
    logic [31:0] last_rd = '0;

    xillybus_loop_fifo #(.DW(DW), .AW(AW)) dut (
        .bus_clk          (bus_clk),
        .reset            (reset),
        .quiesce          (quiesce),
        .user_w_hcw_wren  (user_w_hcw_wren),
        .user_w_hcw_data  (user_w_hcw_data),
        .user_w_hcw_full  (user_w_hcw_full),
        .user_w_hcw_open  (user_w_hcw_open),
        .user_r_hcr_rden  (user_r_hcr_rden),
        .user_r_hcr_data  (user_r_hcr_data),
        .user_r_hcr_empty (user_r_hcr_empty),
        .user_r_hcr_eof   (user_r_hcr_eof),
        .user_r_hcr_open  (user_r_hcr_open),
        .fill_level       (fill_level),
        .overflow         (overflow)
    );

    always #5 bus_clk = ~bus_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: read data is due one edge after an accepted rden.
    always @(negedge bus_clk) begin : monitor
        logic [31:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rd_data", {32'd0, user_r_hcr_data}, {32'd0, e});
        end
    end

    task automatic check_flags(input string name);
        chk({name, " fill"},  64'(fill_level), 64'(mq.size()));
        chk({name, " empty"}, 64'(user_r_hcr_empty), 64'(mq.size() == 0));
        chk({name, " full"},  64'(user_w_hcw_full), 64'(mq.size() == DEPTH));
        chk({name, " ovf"},   64'(overflow), 64'(movf));
    endtask

    // One clock of stimulus; the reference FIFO is updated with the
    // acceptance rules judged on the pre-edge occupancy.
    task automatic do_cycle(input logic w, input logic [31:0] d, input logic r);
        logic ra, wa;
        logic [31:0] rv;
        rv = '0;
        ra = r && (mq.size() > 0);
        wa = w && (mq.size() < DEPTH);
        if (w && !wa) movf = 1'b1;
        if (ra) rv = mq.pop_front();
        if (wa) mq.push_back(d);
        user_w_hcw_wren = w;
        user_w_hcw_data = d;
        user_r_hcr_rden = r;
        @(posedge bus_clk);
        #1;
        if (ra) begin
            exp_q.push_back(rv);
            last_rd = rv;
        end
        user_w_hcw_wren = 1'b0;
        user_r_hcr_rden = 1'b0;
    endtask

    function automatic logic [31:0] pat(input int i);
        return 32'(i) * 32'h9E37_79B9 + 32'd7;
    endfunction

    initial begin
        // Reset
        repeat (3) @(posedge bus_clk);
        #1;
        reset = 1'b0;
        check_flags("reset");
        chk("reset eof", 64'(user_r_hcr_eof), 64'd0);
        chk("reset data", 64'(user_r_hcr_data), 64'd0);

        // 1: 16 words in, 16 out in order
        user_w_hcw_open = 1'b1;
        user_r_hcr_open = 1'b1;
        do_cycle(1'b0, '0, 1'b0);
        for (int i = 1; i <= 16; i++) do_cycle(1'b1, 32'(i), 1'b0);
        check_flags("t1 written");
        for (int i = 0; i < 16; i++) do_cycle(1'b0, '0, 1'b1);
        check_flags("t1 drained");
        chk("t1 eof", 64'(user_r_hcr_eof), 64'd0);

        // 2: fill to 512, overflow on 513th
        for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, 32'hA000_0000 + 32'(i), 1'b0);
        check_flags("t2 full");
        chk("t2 full flag", 64'(user_w_hcw_full), 64'd1);
        do_cycle(1'b1, 32'hDEAD_BEEF, 1'b0);
        check_flags("t2 dropped");
        chk("t2 ovf flag", 64'(overflow), 64'd1);

        // 5: full FIFO, same-cycle write+read: write dropped, word 0 intact
        do_cycle(1'b1, 32'hBAD0_0001, 1'b1);
        check_flags("t5 full rw");
        chk("t5 fill 511", 64'(fill_level), 64'd511);
        for (int i = 1; i < DEPTH; i++) do_cycle(1'b0, '0, 1'b1);
        do_cycle(1'b0, '0, 1'b0);
        check_flags("t2 drained");

        // 4: one word, same-cycle write+read keeps count and returns old word
        do_cycle(1'b1, 32'h1111_1111, 1'b0);
        do_cycle(1'b1, 32'h2222_2222, 1'b1);
        check_flags("t4 one rw");
        chk("t4 fill 1", 64'(fill_level), 64'd1);
        do_cycle(1'b0, '0, 1'b1);
        do_cycle(1'b0, '0, 1'b0);
        // Empty FIFO with write+read: write taken, read ignored, data holds
        do_cycle(1'b1, 32'h3333_3333, 1'b1);
        check_flags("t4 empty rw");
        chk("t4 data hold", 64'(user_r_hcr_data), 64'(last_rd));
        chk("t4 hold val", 64'(user_r_hcr_data), 64'h2222_2222);
        do_cycle(1'b0, '0, 1'b1);

        // 3: writer closes with 4 words buffered, reader drains them
        for (int i = 0; i < 4; i++) do_cycle(1'b1, 32'h40 + 32'(i), 1'b0);
        user_w_hcw_open = 1'b0;
        do_cycle(1'b0, '0, 1'b0);
        chk("t3 eof drain", 64'(user_r_hcr_eof), 64'd0);
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b0, '0, 1'b1);
            chk($sformatf("t3 eof rd%0d", i), 64'(user_r_hcr_eof), 64'(i == 3));
        end
        check_flags("t3 empty");
        user_r_hcr_open = 1'b0;
        do_cycle(1'b0, '0, 1'b0);
        chk("t3 eof close", 64'(user_r_hcr_eof), 64'd0);

        // Writer closes on an empty FIFO with reader open: EOF one cycle later
        user_r_hcr_open = 1'b1;
        do_cycle(1'b0, '0, 1'b0);
        user_w_hcw_open = 1'b1;
        do_cycle(1'b0, '0, 1'b0);
        user_w_hcw_open = 1'b0;
        do_cycle(1'b0, '0, 1'b0);
        chk("eofe drain", 64'(user_r_hcr_eof), 64'd0);
        do_cycle(1'b0, '0, 1'b0);
        chk("eofe eof", 64'(user_r_hcr_eof), 64'd1);
        do_cycle(1'b0, '0, 1'b1);
        chk("eofe sticky", 64'(user_r_hcr_eof), 64'd1);
        check_flags("eofe empty");
        // Late write while in EOF: stored, eof drops
        do_cycle(1'b1, 32'h5555_5555, 1'b0);
        chk("late eof", 64'(user_r_hcr_eof), 64'd0);
        check_flags("late write");
        do_cycle(1'b0, '0, 1'b1);
        chk("late eof2", 64'(user_r_hcr_eof), 64'd0);

        // 6: quiesce with 100 words buffered (overflow still set from t2)
        user_w_hcw_open = 1'b1;
        do_cycle(1'b0, '0, 1'b0);
        for (int i = 0; i < 100; i++) do_cycle(1'b1, 32'h600 + 32'(i), 1'b0);
        check_flags("t6 pre");
        quiesce = 1'b1;
        @(posedge bus_clk);
        #1;
        quiesce = 1'b0;
        mq.delete();
        movf = 1'b0;
        check_flags("t6 quiesce");
        chk("t6 eof", 64'(user_r_hcr_eof), 64'd0);
        chk("t6 data", 64'(user_r_hcr_data), 64'd0);
        // In IDLE a writer close must not lead to DRAIN/EOF
        user_w_hcw_open = 1'b0;
        repeat (3) do_cycle(1'b0, '0, 1'b0);
        chk("t6 idle eof", 64'(user_r_hcr_eof), 64'd0);

        // Wrap: stream 3x512 words through with one word in flight
        do_cycle(1'b1, pat(0), 1'b0);
        for (int i = 1; i < 3 * DEPTH; i++) do_cycle(1'b1, pat(i), 1'b1);
        do_cycle(1'b0, '0, 1'b1);
        do_cycle(1'b0, '0, 1'b0);
        check_flags("wrap end");

        do_cycle(1'b0, '0, 1'b0);
        chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
